// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory req/ack port plus the fetch/decode hand-off.
// The master side is the fetch stage; the slave side is memory, decode and execute.
interface if_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instruction_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rdata_i,
    input  stall_i, br_taken_i, br_target_i,
    output if_id_valid_o, if_id_instruction_o, if_id_pc_o, if_id_pc_plus4_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rdata_i,
    output stall_i, br_taken_i, br_target_i,
    input  if_id_valid_o, if_id_instruction_o, if_id_pc_o, if_id_pc_plus4_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, buffers
// returned words in a small FIFO and presents {instruction, pc, pc+4} to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_stage_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t           state_q;
  logic             req_q;
  logic [31:0]      addr_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_next;
  logic             valid, push, pop, room;
  logic [31:0]      target;

  always_comb begin
    target     = bus.br_target_i & ~32'h0000_0003;
    valid      = (count_q != '0);
    push       = (state_q == REQ) && bus.imem_ack_i && !bus.br_taken_i;
    pop        = valid && !bus.stall_i && !bus.br_taken_i;
    count_next = count_q;
    if (bus.br_taken_i)
      count_next = '0;
    else if (push && !pop)
      count_next = count_q + CNT_W'(1);
    else if (!push && pop)
      count_next = count_q - CNT_W'(1);
    room       = (count_next < DEPTH_C);
  end

  // Control state; addr_q doubles as the drop address while in DISCARD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= count_next;
      if (bus.br_taken_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        pc_q     <= target;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          pc_q     <= pc_q + 32'd4;
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (bus.br_taken_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= target;
          end else if (room) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (bus.br_taken_i) begin
            if (bus.imem_ack_i)
              addr_q  <= target;
            else
              state_q <= DISCARD;
          end else if (bus.imem_ack_i) begin
            if (room) begin
              addr_q <= pc_q + 32'd4;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (bus.imem_ack_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage holds data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rdata_i;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

  assign bus.imem_req_o          = req_q;
  assign bus.imem_addr_o         = addr_q;
  assign bus.if_id_valid_o       = valid;
  assign bus.if_id_instruction_o = valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
  assign bus.if_id_pc_o          = valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign bus.if_id_pc_plus4_o    = valid ? (pc_mem[rd_ptr_q] + 32'd4) : 32'h0;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (count_q < DEPTH_C));
endmodule
